// File: rtl/m_useq.sv
// Microsequencer: selects the next control-store address from the MIR COND/JADDR
// fields, PSR flags and IR, holding while memory is busy and trapping on timeout.
module m_useq #(
  parameter int unsigned        AW        = 11,
  parameter int unsigned        STALL_MAX = 16,
  parameter logic [AW-1:0]      TRAP_ADDR = 11'h7F0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [40:0]   mir,
  input  logic [31:0]   ir,
  input  logic          psr_n,
  input  logic          psr_z,
  input  logic          psr_v,
  input  logic          psr_c,
  input  logic          mem_wait,
  output logic [AW-1:0] cs_addr,
  output logic          stalled,
  output logic          bus_err,
  output logic          taken
);

  localparam int unsigned CW = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t         state, state_d;
  logic [AW-1:0]  addr_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           stalled_d, bus_err_d;

  logic [2:0]     cond;
  logic [AW-1:0]  jaddr;
  logic [AW-1:0]  seq_addr;
  logic [AW-1:0]  dec_addr;
  logic           mem_req;
  logic           hit;
  logic [AW-1:0]  next_addr;

  assign cond     = mir[13:11];
  assign jaddr    = AW'(mir[10:0]);
  assign mem_req  = mir[19] | mir[18];
  assign seq_addr = cs_addr + AW'(1);
  assign dec_addr = AW'({1'b1, ir[31:30], ir[24:19], 2'b00});

  logic unused_bits;
  assign unused_bits = ^{mir[40:20], mir[17:14], ir[29:25], ir[18:14], ir[12:0]};

  always_comb begin
    hit = 1'b0;
    case (cond)
      3'b001:  hit = psr_n;
      3'b010:  hit = psr_z;
      3'b011:  hit = psr_v;
      3'b100:  hit = psr_c;
      3'b101:  hit = ir[13];
      3'b110:  hit = 1'b1;
      3'b111:  hit = 1'b1;
      default: hit = 1'b0;
    endcase
  end

  assign next_addr = (cond == 3'b111) ? dec_addr :
                     hit              ? jaddr    : seq_addr;

  // Microinstruction 0 is implied during RESET, so no branch can be reported.
  assign taken = hit && (state != RESET);

  always_comb begin
    state_d   = state;
    addr_d    = cs_addr;
    cnt_d     = cnt;
    stalled_d = stalled;
    bus_err_d = bus_err;
    case (state)
      RESET: begin
        addr_d  = AW'(1);
        state_d = RUN;
      end
      RUN: begin
        if (mem_req && mem_wait) begin
          stalled_d = 1'b1;
          cnt_d     = CW'(1);
          state_d   = STALL;
        end else begin
          addr_d = next_addr;
        end
      end
      STALL: begin
        if (!mem_wait) begin
          addr_d    = next_addr;
          stalled_d = 1'b0;
          cnt_d     = '0;
          state_d   = RUN;
        end else if (cnt == CW'(STALL_MAX)) begin
          addr_d    = TRAP_ADDR;
          bus_err_d = 1'b1;
          stalled_d = 1'b0;
          cnt_d     = '0;
          state_d   = RUN;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RESET;
      cs_addr <= '0;
      cnt     <= '0;
      stalled <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_d;
      cs_addr <= addr_d;
      cnt     <= cnt_d;
      stalled <= stalled_d;
      bus_err <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_m_useq.sv
// Directed self-checking bench for m_useq; the bench plays the role of the MIR.
module tb_m_useq;

  localparam int unsigned AW        = 11;
  localparam int unsigned STALL_MAX = 16;

  logic          clk;
  logic          rst;
  logic [40:0]   mir;
  logic [31:0]   ir;
  logic          psr_n, psr_z, psr_v, psr_c;
  logic          mem_wait;
  logic [AW-1:0] cs_addr;
  logic          stalled;
  logic          bus_err;
  logic          taken;

  int checks = 0;
  int errors = 0;

  m_useq #(
    .AW        (AW),
    .STALL_MAX (STALL_MAX),
    .TRAP_ADDR (11'h7F0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mir      (mir),
    .ir       (ir),
    .psr_n    (psr_n),
    .psr_z    (psr_z),
    .psr_v    (psr_v),
    .psr_c    (psr_c),
    .mem_wait (mem_wait),
    .cs_addr  (cs_addr),
    .stalled  (stalled),
    .bus_err  (bus_err),
    .taken    (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] cond, input logic [10:0] ja,
                       input logic rd, input logic wr);
    mir        = '0;
    mir[13:11] = cond;
    mir[10:0]  = ja;
    mir[19]    = rd;
    mir[18]    = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mir = '0; ir = '0; mem_wait = 1'b0;
    psr_n = 1'b0; psr_z = 1'b0; psr_v = 1'b0; psr_c = 1'b0;

    // Reset state; a branch word in the MIR must not report taken.
    drive(3'b110, 11'h155, 1'b0, 1'b0);
    #1;
    chk("rst_addr", 32'(cs_addr), 32'h0);
    chk("rst_stalled", 32'(stalled), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_taken", 32'(taken), 32'h0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("first_edge", 32'(cs_addr), 32'h1);

    // Sequential stepping.
    drive(3'b000, 11'h155, 1'b0, 1'b0);
    #1 chk("seq_taken", 32'(taken), 32'h0);
    tick(); chk("seq2", 32'(cs_addr), 32'h2);
    tick(); chk("seq3", 32'(cs_addr), 32'h3);

    // Wrap at the top of the address space.
    drive(3'b110, 11'h7FE, 1'b0, 1'b0);
    tick(); chk("jmp_7fe", 32'(cs_addr), 32'h7FE);
    drive(3'b000, 11'h0, 1'b0, 1'b0);
    tick(); chk("seq_7ff", 32'(cs_addr), 32'h7FF);
    tick(); chk("wrap_0", 32'(cs_addr), 32'h0);

    // Conditional branches, each flag taken then not taken.
    drive(3'b010, 11'h155, 1'b0, 1'b0); psr_z = 1'b1;
    #1 chk("z_taken", 32'(taken), 32'h1);
    tick(); chk("z_jmp", 32'(cs_addr), 32'h155);
    psr_z = 1'b0;
    #1 chk("z_ntaken", 32'(taken), 32'h0);
    tick(); chk("z_seq", 32'(cs_addr), 32'h156);

    drive(3'b001, 11'h100, 1'b0, 1'b0); psr_n = 1'b1;
    tick(); chk("n_jmp", 32'(cs_addr), 32'h100);
    psr_n = 1'b0;
    tick(); chk("n_seq", 32'(cs_addr), 32'h101);

    drive(3'b011, 11'h200, 1'b0, 1'b0); psr_v = 1'b1;
    tick(); chk("v_jmp", 32'(cs_addr), 32'h200);
    psr_v = 1'b0;
    tick(); chk("v_seq", 32'(cs_addr), 32'h201);

    drive(3'b100, 11'h300, 1'b0, 1'b0); psr_c = 1'b1;
    tick(); chk("c_jmp", 32'(cs_addr), 32'h300);
    psr_c = 1'b0;
    tick(); chk("c_seq", 32'(cs_addr), 32'h301);

    drive(3'b101, 11'h400, 1'b0, 1'b0); ir = 32'h0000_2000;
    #1 chk("ir13_taken", 32'(taken), 32'h1);
    tick(); chk("ir13_jmp", 32'(cs_addr), 32'h400);
    ir = 32'h0;
    tick(); chk("ir13_seq", 32'(cs_addr), 32'h401);

    // A flag other than the one COND selects must not cause a branch.
    drive(3'b010, 11'h155, 1'b0, 1'b0); psr_n = 1'b1; psr_v = 1'b1; psr_c = 1'b1;
    #1 chk("z_other_taken", 32'(taken), 32'h0);
    tick(); chk("z_other_seq", 32'(cs_addr), 32'h402);
    psr_n = 1'b0; psr_v = 1'b0; psr_c = 1'b0;

    // Decode dispatch and unconditional jump.
    drive(3'b111, 11'h123, 1'b0, 1'b0); ir = 32'h81C0_0000;
    #1 chk("dec_taken", 32'(taken), 32'h1);
    tick(); chk("decode", 32'(cs_addr), 32'h6E0);
    ir = 32'h0;
    drive(3'b110, 11'h7FF, 1'b0, 1'b0);
    tick(); chk("jmp_7ff", 32'(cs_addr), 32'h7FF);

    // Short read stall, then release applies the pending branch.
    drive(3'b110, 11'h030, 1'b1, 1'b0); mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", 32'(cs_addr), 32'h7FF);
      chk("stall_flag", 32'(stalled), 32'h1);
    end
    mem_wait = 1'b0;
    tick(); chk("stall_release", 32'(cs_addr), 32'h030);
    chk("stall_clear", 32'(stalled), 32'h0);

    // mem_wait without RD/WR does not stall.
    drive(3'b000, 11'h0, 1'b0, 1'b0); mem_wait = 1'b1;
    tick(); chk("wait_no_req", 32'(cs_addr), 32'h031);
    chk("wait_no_req_st", 32'(stalled), 32'h0);

    // Write stall timeout: STALL_MAX held edges, trap on the next.
    drive(3'b000, 11'h0, 1'b0, 1'b1);
    for (int i = 0; i < int'(STALL_MAX); i++) begin
      tick();
      chk("to_hold", 32'(cs_addr), 32'h031);
    end
    chk("to_pre_err", 32'(bus_err), 32'h0);
    tick(); chk("trap_addr", 32'(cs_addr), 32'h7F0);
    chk("trap_err", 32'(bus_err), 32'h1);
    chk("trap_stalled", 32'(stalled), 32'h0);
    mem_wait = 1'b0; drive(3'b000, 11'h0, 1'b0, 1'b0);
    tick(); chk("post_trap_seq", 32'(cs_addr), 32'h7F1);
    chk("err_sticky", 32'(bus_err), 32'h1);

    // A second timeout traps again.
    drive(3'b000, 11'h0, 1'b0, 1'b1); mem_wait = 1'b1;
    for (int i = 0; i < int'(STALL_MAX); i++) tick();
    chk("retrap_hold", 32'(cs_addr), 32'h7F1);
    tick(); chk("retrap_addr", 32'(cs_addr), 32'h7F0);
    chk("retrap_err", 32'(bus_err), 32'h1);

    // Reset in the middle of a stall.
    drive(3'b000, 11'h0, 1'b1, 1'b0);
    tick(); chk("pre_rst_stall", 32'(stalled), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_stall_addr", 32'(cs_addr), 32'h0);
    chk("rst_stall_st", 32'(stalled), 32'h0);
    chk("rst_stall_err", 32'(bus_err), 32'h0);
    drive(3'b110, 11'h155, 1'b1, 1'b0);
    tick(); chk("rst_held", 32'(cs_addr), 32'h0);
    @(negedge clk) rst = 1'b0;
    tick(); chk("rst_exit_addr", 32'(cs_addr), 32'h1);
    chk("rst_exit_nostall", 32'(stalled), 32'h0);
    chk("run_taken", 32'(taken), 32'h1);

    // Reset while a branch is being taken.
    mem_wait = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_br_addr", 32'(cs_addr), 32'h0);
    chk("rst_br_taken", 32'(taken), 32'h0);
    @(negedge clk) rst = 1'b0;
    tick(); chk("rst_br_exit", 32'(cs_addr), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
